// File: rtl/jtframe_rom_arb_if.sv
// Bus bundle between ROM clients, the ROM arbiter and the SDRAM controller.
// The arbiter takes the slave view; whatever drives clients and SDRAM takes the master view.
interface jtframe_rom_arb_if #(
  parameter int CH = 4,
  parameter int AW = 22,
  parameter int DW = 32
);
  logic             downloading;
  logic [CH-1:0]    ch_req;
  logic [CH*AW-1:0] ch_addr;
  logic [CH-1:0]    ch_ok;
  logic [CH*DW-1:0] ch_dout;
  logic             sdram_req;
  logic [AW-1:0]    sdram_addr;
  logic             sdram_ack;
  logic             data_rdy;
  logic [DW-1:0]    data_read;
  logic             refresh_en;

  modport slave (
    input  downloading, ch_req, ch_addr, sdram_ack, data_rdy, data_read,
    output ch_ok, ch_dout, sdram_req, sdram_addr, refresh_en
  );

  modport master (
    output downloading, ch_req, ch_addr, sdram_ack, data_rdy, data_read,
    input  ch_ok, ch_dout, sdram_req, sdram_addr, refresh_en
  );
endinterface

// File: rtl/jtframe_rom_arb.sv
// Multi-channel ROM arbiter: each channel keeps a one-word cache and misses are
// fetched from SDRAM one at a time, round-robin or fixed-priority.
module jtframe_rom_arb #(
  parameter int CH = 4,
  parameter int AW = 22,
  parameter int DW = 32,
  parameter int RR = 1
) (
  input  logic              clk,
  input  logic              rst,
  jtframe_rom_arb_if.slave  bus
);
  localparam int IW = $clog2(CH);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_RDY} state_t;

  state_t        state_q, state_d;
  logic [CH-1:0] valid_q, valid_d;
  logic [AW-1:0] tag_q  [CH];
  logic [AW-1:0] tag_d  [CH];
  logic [DW-1:0] data_q [CH];
  logic [DW-1:0] data_d [CH];
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] last_grant_q, last_grant_d;
  logic          sdram_req_q, sdram_req_d;
  logic [AW-1:0] sdram_addr_q, sdram_addr_d;

  logic [AW-1:0] addr_arr [CH];
  logic [CH-1:0] hit;
  logic [CH-1:0] miss;
  logic          found;
  logic [IW-1:0] pick;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    assign addr_arr[i]                = bus.ch_addr[i*AW +: AW];
    assign hit[i]                     = bus.ch_req[i] & valid_q[i] & (tag_q[i] == addr_arr[i]);
    assign bus.ch_dout[i*DW +: DW]    = data_q[i];
  end

  assign miss           = bus.ch_req & ~hit;
  assign bus.ch_ok      = hit;
  assign bus.sdram_req  = sdram_req_q;
  assign bus.sdram_addr = sdram_addr_q;
  assign bus.refresh_en = ((state_q == IDLE) && (miss == '0)) || bus.downloading;

  // Round-robin starts the scan just past the last winner; fixed priority starts at 0.
  always_comb begin
    int            c;
    logic [IW-1:0] ci;
    found = 1'b0;
    pick  = '0;
    c     = 0;
    ci    = '0;
    for (int k = 0; k < CH; k++) begin
      if (RR != 0) c = int'(last_grant_q) + 1 + k;
      else         c = k;
      if (c >= CH) c = c - CH;
      ci = IW'(c);
      if (!found && miss[ci]) begin
        found = 1'b1;
        pick  = ci;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    tag_d        = tag_q;
    data_d       = data_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    sdram_req_d  = sdram_req_q;
    sdram_addr_d = sdram_addr_q;
    // A download rewrites ROM contents, so every cached word is stale.
    if (bus.downloading) begin
      valid_d     = '0;
      state_d     = IDLE;
      sdram_req_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            grant_d      = pick;
            last_grant_d = pick;
            sdram_addr_d = addr_arr[pick];
            sdram_req_d  = 1'b1;
            state_d      = WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (bus.sdram_ack) begin
            sdram_req_d = 1'b0;
            state_d     = WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          // Stored under the address that was fetched, not the client's current one.
          if (bus.data_rdy) begin
            tag_d[grant_q]   = sdram_addr_q;
            data_d[grant_q]  = bus.data_read;
            valid_d[grant_q] = 1'b1;
            state_d          = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      for (int i = 0; i < CH; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
      grant_q      <= '0;
      last_grant_q <= IW'(CH - 1);
      sdram_req_q  <= 1'b0;
      sdram_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      tag_q        <= tag_d;
      data_q       <= data_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      sdram_req_q  <= sdram_req_d;
      sdram_addr_q <= sdram_addr_d;
    end
  end
endmodule

// File: tb/tb_jtframe_rom_arb.sv
// Bench for jtframe_rom_arb: directed corner cases, a hit/refresh vector table and
// a randomized run against a transaction-level cache/arbitration model.
module tb_jtframe_rom_arb;
  localparam int CH = 4;
  localparam int AW = 22;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             downloading;
  logic [CH-1:0]    ch_req;
  logic [AW-1:0]    addr_arr [CH];
  logic [CH*AW-1:0] ch_addr;
  logic             sdram_ack;
  logic             data_rdy;
  logic [DW-1:0]    data_read;
  logic [DW-1:0]    dout_arr [CH];

  int tests_run = 0;
  int fails     = 0;
  int req_rises = 0;
  logic prev_req = 1'b0;

  always #5 clk = ~clk;

  jtframe_rom_arb_if #(.CH(CH), .AW(AW), .DW(DW)) bus_rr ();
  jtframe_rom_arb_if #(.CH(CH), .AW(AW), .DW(DW)) bus_fp ();

  for (genvar g = 0; g < CH; g++) begin : g_pack
    assign ch_addr[g*AW +: AW] = addr_arr[g];
    assign dout_arr[g]         = bus_rr.ch_dout[g*DW +: DW];
  end

  assign bus_rr.downloading = downloading;
  assign bus_rr.ch_req      = ch_req;
  assign bus_rr.ch_addr     = ch_addr;
  assign bus_rr.sdram_ack   = sdram_ack;
  assign bus_rr.data_rdy    = data_rdy;
  assign bus_rr.data_read   = data_read;
  assign bus_fp.downloading = downloading;
  assign bus_fp.ch_req      = ch_req;
  assign bus_fp.ch_addr     = ch_addr;
  assign bus_fp.sdram_ack   = sdram_ack;
  assign bus_fp.data_rdy    = data_rdy;
  assign bus_fp.data_read   = data_read;

  jtframe_rom_arb #(.CH(CH), .AW(AW), .DW(DW), .RR(1)) dut_rr (
    .clk (clk),
    .rst (rst),
    .bus (bus_rr)
  );

  jtframe_rom_arb #(.CH(CH), .AW(AW), .DW(DW), .RR(0)) dut_fp (
    .clk (clk),
    .rst (rst),
    .bus (bus_fp)
  );

  always @(negedge clk) begin
    if (bus_rr.sdram_req && !prev_req) req_rises++;
    prev_req = bus_rr.sdram_req;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [CH-1:0] req, input logic [AW-1:0] a0,
                               input logic [AW-1:0] a1, input logic [AW-1:0] a3);
    ch_req      = req;
    addr_arr[0] = a0;
    addr_arr[1] = a1;
    addr_arr[3] = a3;
  endtask

  task automatic doReset();
    rst         = 1'b1;
    downloading = 1'b0;
    ch_req      = '0;
    sdram_ack   = 1'b0;
    data_rdy    = 1'b0;
    data_read   = '0;
    for (int i = 0; i < CH; i++) addr_arr[i] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Called in the low phase after the grant edge; ends on the negedge after the data edge.
  task automatic serve(input int ackd, input int rdyd, input logic [DW-1:0] d);
    for (int k = 0; k < ackd; k++) begin
      @(negedge clk);
      #1 checkOutput("req_hold", 128'(bus_rr.sdram_req), 128'(1));
    end
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    #1 checkOutput("req_drop", 128'(bus_rr.sdram_req), 128'(0));
    for (int k = 0; k < rdyd; k++) begin
      sdram_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      sdram_ack = 1'b0;
    end
    data_rdy  = 1'b1;
    data_read = d;
    @(negedge clk);
    data_rdy = 1'b0;
  endtask

  function automatic int pickModel(input logic [CH-1:0] m, input int last, input bit rr);
    for (int k = 0; k < CH; k++) begin
      int c;
      c = rr ? (last + 1 + k) % CH : k;
      if (m[c]) return c;
    end
    return 0;
  endfunction

  typedef struct {
    logic [CH-1:0] req;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [AW-1:0] a3;
    logic [CH-1:0] ok;
    logic          rf;
  } vec_t;

  initial begin
    vec_t          tbl [7];
    logic [AW-1:0] exp_rr [5];
    logic [AW-1:0] exp_fp [5];
    logic [CH-1:0] m_valid;
    logic [AW-1:0] m_tag  [CH];
    logic [DW-1:0] m_data [CH];
    int            m_last;
    logic [CH-1:0] exp_ok;
    logic [CH-1:0] m_miss;
    int            g;
    int            rises0;
    logic [DW-1:0] d;

    tbl[0] = '{4'b0001, 22'h1234, 22'h0,    22'h0,    4'b0001, 1'b1};
    tbl[1] = '{4'b0001, 22'h1235, 22'h0,    22'h0,    4'b0000, 1'b0};
    tbl[2] = '{4'b0000, 22'h1234, 22'h0,    22'h0,    4'b0000, 1'b1};
    tbl[3] = '{4'b0010, 22'h1234, 22'h1234, 22'h0,    4'b0000, 1'b0};
    tbl[4] = '{4'b0011, 22'h1234, 22'h0,    22'h0,    4'b0001, 1'b0};
    tbl[5] = '{4'b1001, 22'h1234, 22'h0,    22'h1234, 4'b0001, 1'b0};
    tbl[6] = '{4'b0001, 22'h0,    22'h0,    22'h0,    4'b0000, 1'b0};
    exp_rr = '{22'h100, 22'h101, 22'h102, 22'h103, 22'h110};
    exp_fp = '{22'h100, 22'h110, 22'h111, 22'h112, 22'h113};

    // Reset values
    rst = 1'b1;
    downloading = 1'b0; ch_req = '0; sdram_ack = 1'b0; data_rdy = 1'b0; data_read = '0;
    for (int i = 0; i < CH; i++) addr_arr[i] = '0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_ok",      128'(bus_rr.ch_ok),      128'(0));
    checkOutput("rst_dout",    128'(bus_rr.ch_dout),    128'(0));
    checkOutput("rst_refresh", 128'(bus_rr.refresh_en), 128'(1));
    checkOutput("rst_req",     128'(bus_rr.sdram_req),  128'(0));
    checkOutput("rst_addr",    128'(bus_rr.sdram_addr), 128'(0));
    rst = 1'b0;

    // Single miss then hit
    @(negedge clk);
    #2 rises0 = req_rises;
    applyStimulus(4'b0001, 22'h1234, 22'h0, 22'h0);
    @(negedge clk);
    #1 checkOutput("miss_req",  128'(bus_rr.sdram_req),  128'(1));
    checkOutput("miss_addr", 128'(bus_rr.sdram_addr), 128'(22'h1234));
    serve(1, 2, 32'hDEADBEEF);
    #1 checkOutput("fill_ok", 128'(bus_rr.ch_ok), 128'(4'b0001));
    checkOutput("fill_dout", 128'(dout_arr[0]), 128'(32'hDEADBEEF));
    checkOutput("one_req", 128'(req_rises - rises0), 128'(1));
    repeat (3) @(negedge clk);
    #1 checkOutput("hit_ok", 128'(bus_rr.ch_ok), 128'(4'b0001));
    checkOutput("hit_noreq", 128'(bus_rr.sdram_req), 128'(0));
    checkOutput("hit_count", 128'(req_rises - rises0), 128'(1));

    // Hit/refresh vector table against the single filled line
    for (int v = 0; v < 7; v++) begin
      @(negedge clk);
      applyStimulus(tbl[v].req, tbl[v].a0, tbl[v].a1, tbl[v].a3);
      #1 checkOutput($sformatf("vec%0d_ok", v), 128'(bus_rr.ch_ok), 128'(tbl[v].ok));
      checkOutput($sformatf("vec%0d_refresh", v), 128'(bus_rr.refresh_en), 128'(tbl[v].rf));
      ch_req = '0;
    end

    // Arbitration order for both policies, all channels missing continuously
    doReset();
    for (int i = 0; i < CH; i++) addr_arr[i] = AW'(22'h100 + i);
    ch_req = '1;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      #1 checkOutput($sformatf("rr_grant%0d", t), 128'(bus_rr.sdram_addr), 128'(exp_rr[t]));
      checkOutput($sformatf("fp_grant%0d", t), 128'(bus_fp.sdram_addr), 128'(exp_fp[t]));
      serve(t % 2, 1, DW'($urandom));
      addr_arr[t % CH] = addr_arr[t % CH] + 22'h10;
    end

    // Address change while the fetch is in flight
    doReset();
    ch_req = 4'b0010;
    addr_arr[1] = 22'h10;
    @(negedge clk);
    #1 checkOutput("mid_addr1", 128'(bus_rr.sdram_addr), 128'(22'h10));
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    addr_arr[1] = 22'h20;
    @(negedge clk);
    data_rdy = 1'b1; data_read = 32'hCAFE0001;
    @(negedge clk);
    data_rdy = 1'b0;
    #1 checkOutput("mid_ok", 128'(bus_rr.ch_ok), 128'(0));
    checkOutput("mid_dout", 128'(dout_arr[1]), 128'(32'hCAFE0001));
    addr_arr[1] = 22'h10;
    #1 checkOutput("mid_tag_old", 128'(bus_rr.ch_ok), 128'(4'b0010));
    addr_arr[1] = 22'h20;
    #1;
    @(negedge clk);
    #1 checkOutput("mid_rereq", 128'(bus_rr.sdram_req), 128'(1));
    checkOutput("mid_addr2", 128'(bus_rr.sdram_addr), 128'(22'h20));
    serve(0, 0, 32'hCAFE0002);
    #1 checkOutput("mid_ok2", 128'(bus_rr.ch_ok), 128'(4'b0010));

    // Download during WAIT_ACK, then download racing data_rdy in WAIT_RDY
    doReset();
    ch_req = 4'b0001; addr_arr[0] = 22'h1234;
    @(negedge clk);
    serve(0, 0, 32'hDEADBEEF);
    #1 checkOutput("dl_prefill", 128'(bus_rr.ch_ok), 128'(4'b0001));
    ch_req = 4'b0011; addr_arr[1] = 22'h40;
    @(negedge clk);
    #1 checkOutput("dl_addr", 128'(bus_rr.sdram_addr), 128'(22'h40));
    downloading = 1'b1;
    @(negedge clk);
    #1 checkOutput("dl_req", 128'(bus_rr.sdram_req), 128'(0));
    checkOutput("dl_ok", 128'(bus_rr.ch_ok), 128'(0));
    checkOutput("dl_refresh", 128'(bus_rr.refresh_en), 128'(1));
    data_rdy = 1'b1; data_read = 32'h55;
    @(negedge clk);
    data_rdy = 1'b0; downloading = 1'b0;
    #1 checkOutput("dl_stray_ok", 128'(bus_rr.ch_ok), 128'(0));
    checkOutput("dl_stray_dout", 128'(dout_arr[1]), 128'(0));
    checkOutput("dl_refresh_off", 128'(bus_rr.refresh_en), 128'(0));
    @(negedge clk);
    #1 checkOutput("dl_regrant", 128'(bus_rr.sdram_addr), 128'(22'h1234));
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    downloading = 1'b1; data_rdy = 1'b1; data_read = 32'h99;
    @(negedge clk);
    downloading = 1'b0; data_rdy = 1'b0;
    #1 checkOutput("dl_race_ok", 128'(bus_rr.ch_ok), 128'(0));
    checkOutput("dl_race_dout", 128'(dout_arr[0]), 128'(32'hDEADBEEF));

    // Reset while waiting for data, then a late data_rdy
    doReset();
    ch_req = 4'b0100; addr_arr[2] = 22'h77;
    @(negedge clk);
    #1 checkOutput("rstmid_addr", 128'(bus_rr.sdram_addr), 128'(22'h77));
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; data_rdy = 1'b1; data_read = 32'h1111;
    @(negedge clk);
    data_rdy = 1'b0;
    #1 checkOutput("rstmid_ok", 128'(bus_rr.ch_ok), 128'(0));
    checkOutput("rstmid_dout", 128'(dout_arr[2]), 128'(0));

    // Randomized traffic against the cache/arbitration model
    doReset();
    m_valid = '0;
    m_last  = CH - 1;
    for (int i = 0; i < CH; i++) begin
      m_tag[i]  = '0;
      m_data[i] = '0;
    end
    for (int it = 0; it < 80; it++) begin
      ch_req = CH'($urandom);
      for (int i = 0; i < CH; i++) addr_arr[i] = AW'((i << 4) | $urandom_range(0, 3));
      #1;
      for (int i = 0; i < CH; i++)
        exp_ok[i] = ch_req[i] && m_valid[i] && (m_tag[i] == addr_arr[i]);
      checkOutput("rnd_ok", 128'(bus_rr.ch_ok), 128'(exp_ok));
      for (int i = 0; i < CH; i++)
        checkOutput("rnd_dout", 128'(dout_arr[i]), 128'(m_data[i]));
      m_miss = ch_req & ~exp_ok;
      if (m_miss == '0) begin
        checkOutput("rnd_refresh_on", 128'(bus_rr.refresh_en), 128'(1));
        sdram_ack = 1'($urandom_range(0, 1));
        data_rdy  = 1'($urandom_range(0, 1));
        data_read = DW'($urandom);
        @(negedge clk);
        sdram_ack = 1'b0;
        data_rdy  = 1'b0;
        #1 checkOutput("rnd_idle", 128'(bus_rr.sdram_req), 128'(0));
      end else begin
        checkOutput("rnd_refresh_off", 128'(bus_rr.refresh_en), 128'(0));
        g = pickModel(m_miss, m_last, 1'b1);
        @(negedge clk);
        #1 checkOutput("rnd_req", 128'(bus_rr.sdram_req), 128'(1));
        checkOutput("rnd_addr", 128'(bus_rr.sdram_addr), 128'(addr_arr[g]));
        d = DW'($urandom);
        serve($urandom_range(0, 3), $urandom_range(0, 3), d);
        m_valid[g] = 1'b1;
        m_tag[g]   = addr_arr[g];
        m_data[g]  = d;
        m_last     = g;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
